bp_cfg_table: RTL and testbench

//  Runtime-programmable successor to the static processor-config table.

---
 rtl/bp_cfg_table.sv | 171 +++++++++++++++++
 tb/tb_bp_cfg_table.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_table.sv
// Programmable config table: slots written over valid/ready, one slot selected and broadcast to num_chan_p tiles.
// Optional watchdog on the broadcast phase is enabled by defining BP_CFG_TABLE_TIMEOUT_EN.
module bp_cfg_table #(
  parameter int cfg_width_p      = 64,
  parameter int num_cfgs_p       = 16,
  parameter int num_chan_p       = 4,
  parameter int timeout_cycles_p = 255,
  localparam int idx_w = $clog2(num_cfgs_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   w_v_i,
  input  logic [idx_w-1:0]       w_idx_i,
  input  logic [cfg_width_p-1:0] w_data_i,
  output logic                   w_ready_o,
  input  logic                   sel_v_i,
  input  logic [idx_w-1:0]       sel_idx_i,
  output logic                   sel_ready_o,
  output logic [cfg_width_p-1:0] cfg_o,
  output logic [num_chan_p-1:0]  cfg_v_o,
  input  logic [num_chan_p-1:0]  cfg_ack_i,
  output logic [idx_w-1:0]       active_idx_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BCAST = 1'b1;

  function automatic logic idx_legal(input logic [idx_w-1:0] idx);
    return (idx != '0) && ({{(32-idx_w){1'b0}}, idx} < 32'(num_cfgs_p));
  endfunction

  logic [0:0]             state_q, state_d;
  logic [cfg_width_p-1:0] mem_q [num_cfgs_p];
  logic [cfg_width_p-1:0] mem_d [num_cfgs_p];
  logic [num_cfgs_p-1:0]  valid_q, valid_d;
  logic [cfg_width_p-1:0] cfg_q, cfg_d;
  logic [num_chan_p-1:0]  pend_q, pend_d;
  logic [idx_w-1:0]       active_q, active_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   err_pend_q, err_pend_d;
  logic                   w_ready_s, sel_ready_s, w_acc_s, w_ok_s, bypass_s, err_ev_s, err_all_s;
`ifdef BP_CFG_TABLE_TIMEOUT_EN
  localparam int cnt_w = $clog2(timeout_cycles_p + 1);
  logic [cnt_w-1:0]       cnt_q, cnt_d;
`endif

  // Next-state computation for table, FSM, pulses and handshakes
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    valid_d    = valid_q;
    cfg_d      = cfg_q;
    pend_d     = pend_q;
    active_d   = active_q;
    done_d     = 1'b0;
    err_ev_s   = 1'b0;
    bypass_s   = 1'b0;
`ifdef BP_CFG_TABLE_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    w_ready_s   = !((state_q == BCAST) && (w_idx_i == active_q));
    sel_ready_s = (state_q == IDLE);
    w_acc_s     = w_v_i & w_ready_s;
    w_ok_s      = idx_legal(w_idx_i);

    if (w_acc_s) begin
      if (w_ok_s) begin
        mem_d[w_idx_i]   = w_data_i;
        valid_d[w_idx_i] = 1'b1;
      end else begin
        err_ev_s = 1'b1;
      end
    end else begin
      err_ev_s = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (sel_v_i) begin
          // a same-cycle write to the selected slot counts as valid and its data wins
          bypass_s = w_acc_s && w_ok_s && (w_idx_i == sel_idx_i);
          if (idx_legal(sel_idx_i) && (valid_q[sel_idx_i] || bypass_s)) begin
            cfg_d    = bypass_s ? w_data_i : mem_q[sel_idx_i];
            active_d = sel_idx_i;
            pend_d   = '1;
            state_d  = BCAST;
`ifdef BP_CFG_TABLE_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end else begin
            err_ev_s = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BCAST: begin
        pend_d = pend_q & ~cfg_ack_i;
        if (pend_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
`ifdef BP_CFG_TABLE_TIMEOUT_EN
          cnt_d = (|(pend_q & cfg_ack_i)) ? '0 : cnt_q + cnt_w'(1);
          if (cnt_d == cnt_w'(timeout_cycles_p)) begin
            pend_d   = '0;
            state_d  = IDLE;
            err_ev_s = 1'b1;
          end else begin
            state_d = BCAST;
          end
`else
          state_d = BCAST;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase

    // an error colliding with done is deferred one cycle; done cannot repeat back-to-back
    err_all_s  = err_ev_s | err_pend_q;
    err_d      = err_all_s & ~done_d;
    err_pend_d = err_all_s & done_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      mem_q      <= '{default: '0};
      valid_q    <= '0;
      cfg_q      <= '0;
      pend_q     <= '0;
      active_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
`ifdef BP_CFG_TABLE_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      valid_q    <= valid_d;
      cfg_q      <= cfg_d;
      pend_q     <= pend_d;
      active_q   <= active_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
`ifdef BP_CFG_TABLE_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign w_ready_o    = w_ready_s;
  assign sel_ready_o  = sel_ready_s;
  assign cfg_o        = cfg_q;
  assign cfg_v_o      = pend_q;
  assign active_idx_o = active_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_bp_cfg_table.sv
// Scoreboard bench for bp_cfg_table: directed scenarios then randomized traffic against a reference model.
module tb_bp_cfg_table;

  localparam int W   = 64;
  localparam int N   = 16;
  localparam int C   = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          w_v_i = 1'b0;
  logic [3:0]    w_idx_i = 4'd0;
  logic [W-1:0]  w_data_i = 64'd0;
  logic          w_ready_o;
  logic          sel_v_i = 1'b0;
  logic [3:0]    sel_idx_i = 4'd0;
  logic          sel_ready_o;
  logic [W-1:0]  cfg_o;
  logic [C-1:0]  cfg_v_o;
  logic [C-1:0]  cfg_ack_i = 4'd0;
  logic [3:0]    active_idx_o;
  logic          done_o;
  logic          err_o;

  bp_cfg_table #(.cfg_width_p(W), .num_cfgs_p(N), .num_chan_p(C), .timeout_cycles_p(TMO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .w_v_i(w_v_i), .w_idx_i(w_idx_i), .w_data_i(w_data_i), .w_ready_o(w_ready_o),
    .sel_v_i(sel_v_i), .sel_idx_i(sel_idx_i), .sel_ready_o(sel_ready_o),
    .cfg_o(cfg_o), .cfg_v_o(cfg_v_o), .cfg_ack_i(cfg_ack_i),
    .active_idx_o(active_idx_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] cfg;
    logic [C-1:0] v;
    logic [3:0]   act;
    logic         done;
    logic         err;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  // reference model: table contents, broadcast bookkeeping, deferred error
  logic [W-1:0] m_mem [N];
  bit           m_val [N];
  bit           m_busy;
  logic [C-1:0] m_pend;
  logic [3:0]   m_act;
  logic [W-1:0] m_cfg;
  bit           m_errp;
  int           m_cnt;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mem[i] = '0;
      m_val[i] = 1'b0;
    end
    m_busy = 1'b0; m_pend = '0; m_act = '0; m_cfg = '0; m_errp = 1'b0; m_cnt = 0;
  endtask

  task automatic step(input bit r, input bit wv, input logic [3:0] widx, input logic [W-1:0] wd,
                      input bit sv, input logic [3:0] sidx, input logic [C-1:0] ack);
    bit wr, wacc, wok, hit, errev, done, eall, cleared;
    exp_t e;
    @(negedge clk);
    reset_i = r; w_v_i = wv; w_idx_i = widx; w_data_i = wd;
    sel_v_i = sv; sel_idx_i = sidx; cfg_ack_i = ack;
    #1;
    if (r) begin
      model_reset();
      e = '0;
    end else begin
      wr = !(m_busy && widx == m_act);
      chk("w_ready", {63'd0, w_ready_o}, {63'd0, wr});
      chk("sel_ready", {63'd0, sel_ready_o}, {63'd0, !m_busy});
      wacc = wv && wr;
      wok = (widx != 4'd0) && (int'(widx) < N);
      hit = wacc && wok && (widx == sidx);
      errev = 1'b0; done = 1'b0;
      if (!m_busy) begin
        if (sv) begin
          if (sidx != 4'd0 && int'(sidx) < N && (m_val[sidx] || hit)) begin
            m_cfg = hit ? wd : m_mem[sidx];
            m_act = sidx; m_pend = '1; m_busy = 1'b1; m_cnt = 0;
          end else begin
            errev = 1'b1;
          end
        end
      end else begin
        cleared = (m_pend & ack) != '0;
        m_pend = m_pend & ~ack;
        if (m_pend == '0) begin
          m_busy = 1'b0; done = 1'b1;
        end else begin
`ifdef BP_CFG_TABLE_TIMEOUT_EN
          m_cnt = cleared ? 0 : m_cnt + 1;
          if (m_cnt == TMO) begin
            m_pend = '0; m_busy = 1'b0; errev = 1'b1;
          end
`endif
        end
      end
      if (wacc) begin
        if (wok) begin
          m_mem[widx] = wd; m_val[widx] = 1'b1;
        end else begin
          errev = 1'b1;
        end
      end
      eall = errev || m_errp;
      m_errp = eall && done;
      e.cfg = m_cfg; e.v = m_pend; e.act = m_act; e.done = done; e.err = eall && !done;
    end
    q.push_back(e);
  endtask

  task automatic idle(input logic [C-1:0] ack);
    step(1'b0, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, ack);
  endtask

  // monitor: every cycle the DUT presents registered outputs, compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cfg_o", cfg_o, e.cfg);
        chk("cfg_v_o", {60'd0, cfg_v_o}, {60'd0, e.v});
        chk("active_idx_o", {60'd0, active_idx_o}, {60'd0, e.act});
        chk("done_o", {63'd0, done_o}, {63'd0, e.done});
        chk("err_o", {63'd0, err_o}, {63'd0, e.err});
        compared++;
        if (done_o && err_o) begin
          mismatched++;
          $display("FAIL done_err_overlap: got both high expected at most one at %0t", $time);
        end
      end
    end
  end

  initial begin
    model_reset();
    step(1'b1, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 4'h0);
    step(1'b1, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 4'h0);
    // write 3, select 3, all ack on first valid cycle
    step(1'b0, 1'b1, 4'd3, 64'hA5, 1'b0, 4'd0, 4'h0);
    step(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 4'd3, 4'h0);
    idle(4'hF);
    idle(4'h0);
    // illegal selects: slot 0 and unwritten slot 5
    step(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 4'd0, 4'h0);
    step(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 4'd5, 4'h0);
    idle(4'h0);
    // staggered acks
    step(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 4'd3, 4'h0);
    idle(4'h1); idle(4'h0); idle(4'h4); idle(4'h0); idle(4'hA); idle(4'h0);
    // writes during broadcast: active slot blocked, other slot accepted
    step(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 4'd3, 4'h0);
    step(1'b0, 1'b1, 4'd3, 64'h1111, 1'b0, 4'd0, 4'h0);
    step(1'b0, 1'b1, 4'd4, 64'h2222, 1'b0, 4'd0, 4'h0);
    step(1'b0, 1'b1, 4'd0, 64'h3333, 1'b0, 4'd0, 4'hF);
    idle(4'h0); idle(4'h0);
    // same-cycle write+select bypass, then reset mid-broadcast
    step(1'b0, 1'b1, 4'd6, 64'h77, 1'b1, 4'd6, 4'h0);
    idle(4'h0);
    step(1'b1, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 4'h0);
    step(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, 4'd6, 4'h0);
    idle(4'h0);
`ifdef BP_CFG_TABLE_TIMEOUT_EN
    // withheld ack on ch1 triggers the watchdog
    step(1'b0, 1'b1, 4'd2, 64'h55, 1'b1, 4'd2, 4'h0);
    idle(4'hD);
    for (int i = 0; i < TMO + 2; i++) idle(4'h0);
`endif
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), {$urandom, $urandom},
           ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
    end
    idle(4'hF);
    idle(4'h0);
    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d queued expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
